// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync, data-enable and colour.
// Optional internal 8-bar colour test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FPORCH    = 16,
  parameter int H_SYNCPULSE = 96,
  parameter int H_BPORCH    = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FPORCH    = 10,
  parameter int V_SYNCPULSE = 2,
  parameter int V_BPORCH    = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int COLOR_BITS  = 1,
  parameter int CLK_DIV     = 1,
  localparam int H_TOTAL    = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH,
  localparam int V_TOTAL    = V_DISPLAY + V_FPORCH + V_SYNCPULSE + V_BPORCH,
  localparam int XW         = $clog2(H_TOTAL),
  localparam int YW         = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLOR_BITS-1:0] r_in,
  input  logic [COLOR_BITS-1:0] g_in,
  input  logic [COLOR_BITS-1:0] b_in,
  input  logic                  pattern_en,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  active,
  output logic                  pix_tick,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  hsync,
  output logic                  vsync,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  de
);

  if (H_DISPLAY < 1 || H_SYNCPULSE < 1 || V_DISPLAY < 1 || V_SYNCPULSE < 1 ||
      H_FPORCH < 0 || H_BPORCH < 0 || V_FPORCH < 0 || V_BPORCH < 0 ||
      COLOR_BITS < 1 || CLK_DIV < 1 ||
      HSYNC_POL < 0 || HSYNC_POL > 1 || VSYNC_POL < 0 || VSYNC_POL > 1) begin : g_param_check
    $error("vga_timing_gen: illegal parameter set");
  end

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [31:0]   H_ACT    = 32'(H_DISPLAY);
  localparam logic [31:0]   V_ACT    = 32'(V_DISPLAY);
  localparam logic [31:0]   H_SS     = 32'(H_DISPLAY + H_FPORCH);
  localparam logic [31:0]   H_SE     = 32'(H_DISPLAY + H_FPORCH + H_SYNCPULSE);
  localparam logic [31:0]   V_SS     = 32'(V_DISPLAY + V_FPORCH);
  localparam logic [31:0]   V_SE     = 32'(V_DISPLAY + V_FPORCH + V_SYNCPULSE);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_wrap;
  logic          h_in_sync;
  logic          v_in_sync;
  logic [COLOR_BITS-1:0] src_r, src_g, src_b;

  // stage p0: pixel divider and raster counters
  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_wrap   = pix_tick && (h_cnt == H_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_tick ? '0 : div_cnt + 1'b1;
      if (pix_tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end
    end
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign active      = (32'(h_cnt) < H_ACT) && (32'(v_cnt) < V_ACT);
  assign line_start  = pix_tick && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);
  assign h_in_sync   = (32'(h_cnt) >= H_SS) && (32'(h_cnt) < H_SE);
  assign v_in_sync   = (32'(v_cnt) >= V_SS) && (32'(v_cnt) < V_SE);

`ifdef VGA_TEST_PATTERN_EN
  logic [XW+2:0] bar_num;
  logic [2:0]    bar;
  assign bar_num = {h_cnt, 3'b000};
  assign bar     = 3'(bar_num / (XW+3)'(H_DISPLAY));
  assign src_r   = pattern_en ? {COLOR_BITS{bar[2]}} : r_in;
  assign src_g   = pattern_en ? {COLOR_BITS{bar[1]}} : g_in;
  assign src_b   = pattern_en ? {COLOR_BITS{bar[0]}} : b_in;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign src_r = r_in;
  assign src_g = g_in;
  assign src_b = b_in;
`endif

  // stage p1: output register, one pixel behind x/y
  logic                  hsync_p1, vsync_p1, de_p1;
  logic [COLOR_BITS-1:0] r_p1, g_p1, b_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p1 <= ~HS_ON;
      vsync_p1 <= ~VS_ON;
      de_p1    <= 1'b0;
      r_p1     <= '0;
      g_p1     <= '0;
      b_p1     <= '0;
    end else if (pix_tick) begin
      hsync_p1 <= h_in_sync ? HS_ON : ~HS_ON;
      vsync_p1 <= v_in_sync ? VS_ON : ~VS_ON;
      de_p1    <= active;
      r_p1     <= active ? src_r : '0;
      g_p1     <= active ? src_g : '0;
      b_p1     <= active ? src_b : '0;
    end
  end

  assign hsync = hsync_p1;
  assign vsync = vsync_p1;
  assign de    = de_p1;
  assign r     = r_p1;
  assign g     = g_p1;
  assign b     = b_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (divide-by-1 active-low,
// divide-by-2 active-high 4-bit colour) checked against a count-based reference.
module tb_vga_timing_gen;
  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT_BUILD = 1'b1;
`else
  localparam bit PAT_BUILD = 1'b0;
`endif

  typedef struct packed {logic hs; logic vs; logic de; logic [3:0] r; logic [3:0] g; logic [3:0] b;} regs_t;
  localparam regs_t RST0 = '{hs: 1'b1, vs: 1'b1, de: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
  localparam regs_t RST1 = '{hs: 1'b0, vs: 1'b0, de: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pattern_en = 1'b0;
  logic r_in0 = 1'b0, g_in0 = 1'b0, b_in0 = 1'b0;
  logic [3:0] r_in1 = '0, g_in1 = '0, b_in1 = '0;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic active0, pix_tick0, line_start0, frame_start0, hsync0, vsync0, r0, g0, b0, de0;
  logic active1, pix_tick1, line_start1, frame_start1, hsync1, vsync1, de1;
  logic [3:0] r1, g1, b1;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_DISPLAY(HD), .H_FPORCH(HF), .H_SYNCPULSE(HS), .H_BPORCH(HB),
    .V_DISPLAY(VD), .V_FPORCH(VF), .V_SYNCPULSE(VS), .V_BPORCH(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_BITS(1), .CLK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .r_in(r_in0), .g_in(g_in0), .b_in(b_in0), .pattern_en(pattern_en),
    .x(x0), .y(y0), .active(active0), .pix_tick(pix_tick0), .line_start(line_start0),
    .frame_start(frame_start0), .hsync(hsync0), .vsync(vsync0), .r(r0), .g(g0), .b(b0), .de(de0));

  vga_timing_gen #(.H_DISPLAY(HD), .H_FPORCH(HF), .H_SYNCPULSE(HS), .H_BPORCH(HB),
    .V_DISPLAY(VD), .V_FPORCH(VF), .V_SYNCPULSE(VS), .V_BPORCH(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_BITS(4), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .r_in(r_in1), .g_in(g_in1), .b_in(b_in1), .pattern_en(pattern_en),
    .x(x1), .y(y1), .active(active1), .pix_tick(pix_tick1), .line_start(line_start1),
    .frame_start(frame_start1), .hsync(hsync1), .vsync(vsync1), .r(r1), .g(g1), .b(b1), .de(de1));

  int checks = 0;
  int fails = 0;
  int n = 0;
  bit known = 1'b0;
  bit rst_prev = 1'b0;
  regs_t e0 = RST0, e1 = RST1;
  regs_t q0[$], q1[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (clk %0d after reset)", nm, act, exp, n);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  function automatic regs_t reg_exp(int h, int v, bit hp, bit vp,
                                    logic [3:0] ri, logic [3:0] gi, logic [3:0] bi,
                                    logic [3:0] ones, bit pat);
    regs_t e;
    bit a;
    int bar;
    a = (h < HD) && (v < VD);
    bar = (h * 8) / HD;
    if (pat && PAT_BUILD) begin
      ri = bar[2] ? ones : 4'h0;
      gi = bar[1] ? ones : 4'h0;
      bi = bar[0] ? ones : 4'h0;
    end
    e.hs = (h >= HD + HF && h < HD + HF + HS) ? hp : ~hp;
    e.vs = (v >= VD + VF && v < VD + VF + VS) ? vp : ~vp;
    e.de = a;
    e.r  = a ? (ri & ones) : 4'h0;
    e.g  = a ? (gi & ones) : 4'h0;
    e.b  = a ? (bi & ones) : 4'h0;
    return e;
  endfunction

  // One clock: check registered outputs, drive inputs, check combinational outputs, queue expectations.
  task automatic step(bit rst_v, int mode, bit pat);
    int h0, v0, h1, v1, p1;
    bit t1;
    logic [3:0] cr, cg, cb;
    if (rst_prev) begin
      known = 1'b1; n = 0; e0 = RST0; e1 = RST1; q0.delete(); q1.delete();
    end else if (known) begin
      n++;
      if (q0.size() > 0) e0 = q0.pop_front();
      if (q1.size() > 0) e1 = q1.pop_front();
    end
    if (known) begin
      chk("hsync0", hsync0, e0.hs); chk("vsync0", vsync0, e0.vs); chk("de0", de0, e0.de);
      chk("r0", r0, e0.r); chk("g0", g0, e0.g); chk("b0", b0, e0.b);
      chk("hsync1", hsync1, e1.hs); chk("vsync1", vsync1, e1.vs); chk("de1", de1, e1.de);
      chk("r1", r1, e1.r); chk("g1", g1, e1.g); chk("b1", b1, e1.b);
    end
    case (mode)
      0: begin cr = 4'h0; cg = 4'h0; cb = 4'h0; end
      1: begin cr = 4'hF; cg = 4'hF; cb = 4'hF; end
      default: begin cr = 4'($urandom); cg = 4'($urandom); cb = 4'($urandom); end
    endcase
    rst = rst_v; pattern_en = pat;
    r_in0 = cr[0]; g_in0 = cg[0]; b_in0 = cb[0];
    r_in1 = cr; g_in1 = cg; b_in1 = cb;
    #1;
    if (known) begin
      h0 = n % HT; v0 = (n / HT) % VT;
      p1 = n / 2; t1 = (n % 2) == 1; h1 = p1 % HT; v1 = (p1 / HT) % VT;
      chk("x0", x0, h0); chk("y0", y0, v0); chk("active0", active0, (h0 < HD) && (v0 < VD));
      chk("pix_tick0", pix_tick0, 1); chk("line_start0", line_start0, h0 == 0);
      chk("frame_start0", frame_start0, h0 == 0 && v0 == 0);
      chk("x1", x1, h1); chk("y1", y1, v1); chk("active1", active1, (h1 < HD) && (v1 < VD));
      chk("pix_tick1", pix_tick1, t1); chk("line_start1", line_start1, t1 && h1 == 0);
      chk("frame_start1", frame_start1, t1 && h1 == 0 && v1 == 0);
      if (!rst_v) begin
        q0.push_back(reg_exp(h0, v0, 1'b0, 1'b0, cr, cg, cb, 4'h1, pat));
        if (t1) q1.push_back(reg_exp(h1, v1, 1'b1, 1'b1, cr, cg, cb, 4'hF, pat));
      end
    end
    rst_prev = rst_v;
    @(negedge clk);
  endtask

  typedef struct {bit rst; int cycles; int mode; bit pat;} phase_t;
  typedef struct {int n; int x0; int y0; int x1; int y1;} spot_t;
  phase_t ph[6];
  spot_t sp[6];

  initial begin
    int cur, cnt, i;
    ph[0] = '{1'b1, 2, 0, 1'b0};   ph[1] = '{1'b0, 260, 1, 1'b0};
    ph[2] = '{1'b0, 500, 2, 1'b0}; ph[3] = '{1'b0, 500, 2, 1'b1};
    ph[4] = '{1'b1, 3, 2, 1'b0};   ph[5] = '{1'b0, 300, 0, 1'b0};
    sp[0] = '{0, 0, 0, 0, 0};     sp[1] = '{23, 23, 0, 11, 0};
    sp[2] = '{24, 0, 1, 12, 0};   sp[3] = '{50, 2, 2, 1, 1};
    sp[4] = '{239, 23, 9, 23, 4}; sp[5] = '{240, 0, 0, 0, 5};

    @(negedge clk);
    foreach (ph[k]) for (int c = 0; c < ph[k].cycles; c++) step(ph[k].rst, ph[k].mode, ph[k].pat);

    // spot positions counted from reset release
    step(1'b1, 0, 1'b0);
    cur = 0;
    foreach (sp[k]) begin
      while (cur < sp[k].n) begin step(1'b0, 2, 1'b0); cur++; end
      chk("spot_x0", x0, sp[k].x0); chk("spot_y0", y0, sp[k].y0);
      chk("spot_x1", x1, sp[k].x1); chk("spot_y1", y1, sp[k].y1);
    end

    // single-cycle reset in mid-frame
    for (i = 0; i < 400; i++) begin if (x0 == 10 && y0 == 3) break; step(1'b0, 1, 1'b0); end
    if (i == 400) timeout("wait_x10_y3");
    step(1'b1, 1, 1'b0);
    chk("rst_x0", x0, 0); chk("rst_y0", y0, 0); chk("rst_hsync0", hsync0, 1); chk("rst_vsync0", vsync0, 1);
    chk("rst_rgb0", {r0, g0, b0}, 0); chk("rst_de0", de0, 0); chk("rst_hsync1", hsync1, 0);
    chk("rst_rgb1", {r1, g1, b1}, 0); chk("rst_fs0", frame_start0, 1); chk("rst_fs1", frame_start1, 0);
    step(1'b0, 1, 1'b0);
    chk("rel_fs1", frame_start1, 1); chk("rel_fs0", frame_start0, 0);

    // hsync pulse on dut0: first low one tick after x reaches sync start
    for (i = 0; i < 100; i++) begin if (x0 == HD + HF) break; step(1'b0, 2, 1'b0); end
    if (i == 100) timeout("wait_hsync_start");
    chk("hs0_before", hsync0, 1);
    step(1'b0, 2, 1'b0);
    chk("hs0_first_low", hsync0, 0);
    cnt = 1;
    while (cnt < 50) begin step(1'b0, 2, 1'b0); if (hsync0 !== 1'b0) break; cnt++; end
    chk("hs0_width", cnt, HS);

    // active-high hsync on the divided instance, in clocks
    for (i = 0; i < 200; i++) begin if (hsync1 === 1'b1) break; step(1'b0, 2, 1'b0); end
    if (i == 200) timeout("wait_hsync1");
    cnt = 0;
    while (cnt < 100 && hsync1 === 1'b1) begin step(1'b0, 2, 1'b0); cnt++; end
    chk("hs1_width_clks", cnt, 2 * HS);

    // vsync on dut0 starts one tick after (x=0, y=sync start)
    for (i = 0; i < 600; i++) begin if (x0 == 0 && y0 == VD + VF) break; step(1'b0, 2, 1'b0); end
    if (i == 600) timeout("wait_vsync_start");
    chk("vs0_before", vsync0, 1);
    cnt = 0;
    step(1'b0, 2, 1'b0);
    while (cnt < 200 && vsync0 === 1'b0) begin step(1'b0, 2, 1'b0); cnt++; end
    chk("vs0_width", cnt, VS * HT);

    // frame and line periods
    for (i = 0; i < 600; i++) begin if (frame_start0) break; step(1'b0, 2, 1'b0); end
    if (i == 600) timeout("wait_fs0");
    cnt = 0;
    do begin step(1'b0, 2, 1'b0); cnt++; end while (!frame_start0 && cnt < 600);
    chk("frame0_period", cnt, HT * VT);
    cnt = 0;
    do begin step(1'b0, 2, 1'b0); cnt++; end while (!line_start0 && cnt < 100);
    chk("line0_period", cnt, HT);
    for (i = 0; i < 1200; i++) begin if (frame_start1) break; step(1'b0, 2, 1'b0); end
    if (i == 1200) timeout("wait_fs1");
    cnt = 0;
    do begin step(1'b0, 2, 1'b0); cnt++; end while (!frame_start1 && cnt < 1200);
    chk("frame1_period", cnt, 2 * HT * VT);

    // test-pattern source on the 4-bit instance over a full line
    for (i = 0; i < 1200; i++) begin if (line_start1 && y1 == 0) break; step(1'b0, 2, 1'b1); end
    if (i == 1200) timeout("wait_pattern_line");
    for (int c = 0; c < 2 * HT + 2; c++) step(1'b0, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
